ccff_chain_loader: RTL and testbench

- Writer end of the configuration flip-flop (ccff) chain used by the routing and connection blocks.
- Accepts bitstream words on a valid/ready stream and serializes them onto a chain's ccff_head.
- Drives config_enable so that every chained memory cell shifts exactly once per delivered bit.
- Sits between the secured-bitstream decrypt path and one tile-column chain; ccff_tail of the last block returns to it.

---
 rtl/ccff_chain_loader.sv | 216 +++++++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// Writer end of a ccff configuration chain: takes bitstream words on a valid/ready
// stream and shifts them LSB-first onto ccff_head. Define CCFF_READBACK_EN for the CRC verify pass.
module ccff_chain_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 40,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              config_enable,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS = ((CHAIN_LEN % WORD_W) == 0) ? WORD_W : (CHAIN_LEN % WORD_W);
    localparam int HC_W      = $clog2(WORD_W + 1);

    localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] NWORDS_C    = CNT_W'(NWORDS);
    localparam logic [CNT_W-1:0] LAST_IDX_C  = CNT_W'(NWORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [HC_W-1:0]  HC_ZERO     = {HC_W{1'b0}};
    localparam logic [HC_W-1:0]  HC_ONE      = {{(HC_W-1){1'b0}}, 1'b1};
    localparam logic [HC_W-1:0]  FULL_BITS_C = HC_W'(WORD_W);
    localparam logic [HC_W-1:0]  LAST_BITS_C = HC_W'(LAST_BITS);

`ifdef CCFF_READBACK_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_VERIFY = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    // Bit-serial CRC-16-CCITT step (polynomial 0x1021, MSB-first register).
    function automatic logic [15:0] crc16_bit(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        crc16_bit = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FIN  = 2'd3
    } state_t;
`endif

    state_t            state_r;
    state_t            next_state_s;
    logic [WORD_W-1:0] hold_r;
    logic [HC_W-1:0]   hold_cnt_r;
    logic [CNT_W-1:0]  words_taken_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic              ccff_head_r;
    logic              config_enable_r;
    logic              busy_r;
    logic              done_r;
    logic              word_ready_s;
    logic              accept_s;
    logic              shift_s;
    logic              ver_shift_s;
    logic              start_load_s;

`ifdef CCFF_READBACK_EN
    logic [15:0]       crc_load_r;
    logic [15:0]       crc_ver_r;
    logic [CNT_W-1:0]  vcnt_r;
    logic              error_r;
`else
    logic              unused_tail_s;
    assign unused_tail_s = ccff_tail;
`endif

    // Next-state and handshake decode; word_ready depends on registers only.
    always_comb begin
        next_state_s = state_r;
        word_ready_s = (state_r == S_LOAD) && (words_taken_r < NWORDS_C) && (hold_cnt_r <= HC_ONE);
        accept_s     = word_ready_s && word_valid;
        shift_s      = (state_r == S_LOAD) && (hold_cnt_r != HC_ZERO);
        start_load_s = (state_r == S_IDLE) && start;
        ver_shift_s  = 1'b0;
`ifdef CCFF_READBACK_EN
        // Alternate decisions so the tail we sample always reflects the previous shift.
        ver_shift_s  = (state_r == S_VERIFY) && !config_enable_r && (vcnt_r != CHAIN_LEN_C);
`endif
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    next_state_s = S_LOAD;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (bit_cnt_r == CHAIN_LEN_C) begin
`ifdef CCFF_READBACK_EN
                    next_state_s = S_VERIFY;
`else
                    next_state_s = S_FIN;
`endif
                end else begin
                    next_state_s = S_LOAD;
                end
            end
`ifdef CCFF_READBACK_EN
            S_VERIFY: begin
                if ((vcnt_r == CHAIN_LEN_C) && !config_enable_r) begin
                    next_state_s = S_FIN;
                end else begin
                    next_state_s = S_VERIFY;
                end
            end
`endif
            S_FIN: begin
                next_state_s = S_IDLE;
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Holding register, word and bit counters.
    always_ff @(posedge prog_clk) begin
        if (pReset || start_load_s) begin
            hold_r        <= {WORD_W{1'b0}};
            hold_cnt_r    <= HC_ZERO;
            words_taken_r <= CNT_ZERO;
            bit_cnt_r     <= CNT_ZERO;
        end else begin
            if (accept_s) begin
                hold_r        <= word_data;
                hold_cnt_r    <= (words_taken_r == LAST_IDX_C) ? LAST_BITS_C : FULL_BITS_C;
                words_taken_r <= words_taken_r + CNT_ONE;
            end else if (shift_s) begin
                hold_r        <= {1'b0, hold_r[WORD_W-1:1]};
                hold_cnt_r    <= hold_cnt_r - HC_ONE;
            end
            if (shift_s) begin
                bit_cnt_r <= bit_cnt_r + CNT_ONE;
            end
        end
    end

    // Registered chain interface and status outputs.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            ccff_head_r     <= 1'b0;
            config_enable_r <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
        end else begin
            config_enable_r <= shift_s || ver_shift_s;
            if (shift_s) begin
                ccff_head_r <= hold_r[0];
            end else if (ver_shift_s) begin
                ccff_head_r <= ccff_tail;
            end
            busy_r <= (next_state_s != S_IDLE);
            done_r <= (next_state_s == S_FIN);
        end
    end

`ifdef CCFF_READBACK_EN
    // CRCs over driven and returned bits; mismatch latched on entry to FIN.
    always_ff @(posedge prog_clk) begin
        if (pReset || start_load_s) begin
            crc_load_r <= 16'hFFFF;
            crc_ver_r  <= 16'hFFFF;
            vcnt_r     <= CNT_ZERO;
            error_r    <= 1'b0;
        end else begin
            if (shift_s) begin
                crc_load_r <= crc16_bit(crc_load_r, hold_r[0]);
            end
            if (ver_shift_s) begin
                crc_ver_r <= crc16_bit(crc_ver_r, ccff_tail);
                vcnt_r    <= vcnt_r + CNT_ONE;
            end
            if ((state_r == S_VERIFY) && (next_state_s == S_FIN) && (crc_load_r != crc_ver_r)) begin
                error_r <= 1'b1;
            end
        end
    end

    assign error = error_r;
`else
    assign error = 1'b0;
`endif

    assign word_ready    = word_ready_s;
    assign ccff_head     = ccff_head_r;
    assign config_enable = config_enable_r;
    assign busy          = busy_r;
    assign done          = done_r;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with a 40-bit shift-register chain model on the tail.
module tb_ccff_chain_loader;

    logic        prog_clk = 1'b0;
    logic        pReset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] word_data = 32'd0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic        ccff_head;
    logic        config_enable;
    logic        ccff_tail;
    logic        busy;
    logic        done;
    logic        error;

    logic [39:0] chain = 40'd0;
    logic        corrupt = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_cnt = 0;
    int first_en = -1;
    int cyc40 = -1;
    int done_cnt = 0;
    int words_sent = 0;
    int ready_late = 0;
    logic [79:0] stream = 80'd0;

`ifdef CCFF_READBACK_EN
    localparam int EXP_EN = 80;
`else
    localparam int EXP_EN = 40;
`endif

    ccff_chain_loader #(.WORD_W(32), .CHAIN_LEN(40), .CNT_W(16)) dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .ccff_head(ccff_head), .config_enable(config_enable), .ccff_tail(ccff_tail),
        .busy(busy), .done(done), .error(error)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model: head enters bit 0, tail is bit 39; corrupt flips one cell when idle.
    always @(posedge prog_clk) begin
        if (config_enable) chain <= {chain[38:0], ccff_head};
        else if (corrupt) chain <= chain ^ 40'h00_0010_0000;
    end
    assign ccff_tail = chain[39];

    always @(posedge prog_clk) cyc++;

    always @(negedge prog_clk) begin
        if (config_enable) begin
            if (en_cnt < 80) stream[en_cnt] = ccff_head;
            if (first_en < 0) first_en = cyc;
            en_cnt++;
            if (en_cnt == 40) cyc40 = cyc;
        end
        if (done) done_cnt++;
        if (words_sent >= 2 && word_ready) ready_late = 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        en_cnt = 0; first_en = -1; cyc40 = -1; done_cnt = 0;
        words_sent = 0; ready_late = 0; stream = 80'd0;
    endtask

    task automatic send_word(input logic [31:0] w);
        int n;
        n = 0;
        word_data = w;
        word_valid = 1'b1;
        while (word_ready !== 1'b1 && n < 100) begin
            @(negedge prog_clk);
            n++;
        end
        check("word_accept", {63'd0, word_ready}, 64'd1);
        @(posedge prog_clk); #1;
        word_valid = 1'b0;
        words_sent++;
    endtask

    task automatic do_load(input logic [31:0] w1, input logic [31:0] w2, input int gap, input bit mid_start);
        clear_mon();
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        send_word(w1);
        if (mid_start) begin
            repeat (5) @(posedge prog_clk);
            #1 start = 1'b1;
            @(posedge prog_clk); #1;
            start = 1'b0;
        end
        if (gap > 0) begin
            repeat (31 + gap) @(posedge prog_clk);
            #1;
        end
        send_word(w2);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(negedge prog_clk);
            n++;
        end
        check("done_seen", {63'd0, done}, 64'd1);
    endtask

    task automatic wait_en(input int target);
        int n;
        n = 0;
        while (en_cnt < target && n < 200) begin
            @(negedge prog_clk); #1;
            n++;
        end
        check("en_reached", 64'(en_cnt >= target), 64'd1);
    endtask

    function automatic logic [39:0] chain_image(input logic [39:0] bits);
        logic [39:0] r;
        for (int i = 0; i < 40; i++) r[39 - i] = bits[i];
        return r;
    endfunction

    initial begin
        logic [39:0] exp_a;
        logic [39:0] exp_b;
        exp_a = {8'hC3, 32'hA5A5A5A5};
        exp_b = {8'h5A, 32'h12345678};

        // Reset state
        repeat (3) @(posedge prog_clk);
        #1 pReset = 1'b0;
        @(negedge prog_clk);
        check("reset_outputs", {58'd0, word_ready, ccff_head, config_enable, busy, done, error}, 64'd0);

        // word_valid in IDLE is ignored
        clear_mon();
        word_valid = 1'b1;
        word_data = 32'hFFFFFFFF;
        repeat (3) @(negedge prog_clk);
        check("idle_ready", {63'd0, word_ready}, 64'd0);
        word_valid = 1'b0;
        @(posedge prog_clk); #1;
        check("idle_no_enable", 64'(en_cnt), 64'd0);

        // Basic back-to-back load
        do_load(32'hA5A5A5A5, 32'h000000C3, 0, 1'b0);
        wait_done();
        check("basic_error", {63'd0, error}, 64'd0);
        repeat (3) @(posedge prog_clk);
        #1;
        check("basic_en_cnt", 64'(en_cnt), 64'(EXP_EN));
        check("basic_span", 64'(cyc40 - first_en + 1), 64'd40);
        check("basic_stream", {24'd0, stream[39:0]}, {24'd0, exp_a});
        check("basic_done_cnt", 64'(done_cnt), 64'd1);
        check("basic_ready_late", 64'(ready_late), 64'd0);
        check("basic_busy", {63'd0, busy}, 64'd0);
        check("basic_chain", {24'd0, chain}, {24'd0, chain_image(exp_a)});
`ifdef CCFF_READBACK_EN
        check("basic_recirc", {24'd0, stream[79:40]}, {24'd0, exp_a});
`endif

        // Stall of 5 cycles between words
        do_load(32'hA5A5A5A5, 32'h000000C3, 5, 1'b0);
        wait_done();
        repeat (3) @(posedge prog_clk);
        #1;
        check("stall_en_cnt", 64'(en_cnt), 64'(EXP_EN));
        check("stall_span", 64'(cyc40 - first_en + 1), 64'd45);
        check("stall_stream", {24'd0, stream[39:0]}, {24'd0, exp_a});
        check("stall_done_cnt", 64'(done_cnt), 64'd1);

        // Reset mid-load, then a fresh full load with upper bits of the last word discarded
        clear_mon();
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        send_word(32'hA5A5A5A5);
        wait_en(10);
        pReset = 1'b1;
        @(posedge prog_clk); #1;
        pReset = 1'b0;
        check("midreset_outputs", {58'd0, word_ready, ccff_head, config_enable, busy, done, error}, 64'd0);
        repeat (2) @(posedge prog_clk);
        #1;
        check("midreset_idle", {62'd0, busy, config_enable}, 64'd0);
        do_load(32'h12345678, 32'hDEADBE5A, 0, 1'b0);
        wait_done();
        repeat (3) @(posedge prog_clk);
        #1;
        check("reload_en_cnt", 64'(en_cnt), 64'(EXP_EN));
        check("reload_stream", {24'd0, stream[39:0]}, {24'd0, exp_b});
        check("reload_chain", {24'd0, chain}, {24'd0, chain_image(exp_b)});

        // start while busy is ignored
        do_load(32'hA5A5A5A5, 32'h000000C3, 0, 1'b1);
        wait_done();
        repeat (3) @(posedge prog_clk);
        #1;
        check("busy_start_done_cnt", 64'(done_cnt), 64'd1);
        check("busy_start_en_cnt", 64'(en_cnt), 64'(EXP_EN));
        check("busy_start_stream", {24'd0, stream[39:0]}, {24'd0, exp_a});

`ifdef CCFF_READBACK_EN
        // Readback failure: one chain cell flipped before it is read back
        do_load(32'h12345678, 32'hDEADBE5A, 0, 1'b0);
        wait_en(40);
        corrupt = 1'b1;
        @(posedge prog_clk);
        @(posedge prog_clk); #1;
        corrupt = 1'b0;
        wait_done();
        check("rb_fail_error", {63'd0, error}, 64'd1);
        repeat (3) @(posedge prog_clk);
        #1;
        check("rb_fail_en_cnt", 64'(en_cnt), 64'd80);
        check("rb_error_sticky", {63'd0, error}, 64'd1);
        do_load(32'hA5A5A5A5, 32'h000000C3, 0, 1'b0);
        wait_done();
        check("rb_error_cleared", {63'd0, error}, 64'd0);
        repeat (3) @(posedge prog_clk);
        #1;
        check("rb_pass_chain", {24'd0, chain}, {24'd0, chain_image(exp_a)});
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
